// File: rtl/dmg_link_responder.sv
// -----------------------------------------------------------------------------
// dmg_link_responder
//
// Responder (external-clock) end of the DMG serial link port. The partner
// supplies SCK, which idles high. On each detected falling edge the next bit is
// presented on sout. On each detected rising edge one bit of sin is shifted in.
// Data moves MSB first. After eight rising edges the received byte goes to
// rx_data, and rx_valid pulses for one cycle.
//
// sck and sin are asynchronous pins. They pass through identical synchroniser
// chains, so the two stay aligned with each other. A further flop on the
// synchronised SCK provides edge detection. From a pin change to the resulting
// action takes SYNC_STAGES+1 clk cycles.
//
// Ports:
//   clk      system clock, all state changes on the rising edge
//   res      synchronous active-high reset
//   sck      partner link clock (asynchronous, idles high)
//   sin      partner serial data (asynchronous)
//   sout     serial data to the partner
//   tx_data  byte to send, captured on an accepted tx_load
//   tx_load  single-cycle strobe that arms a transfer; ignored while busy
//   busy     transfer armed and not yet completed or aborted
//   rx_data  last received byte, held until the next completion
//   rx_valid one-cycle pulse when rx_data updates
//   err      one-cycle pulse on a timeout abort or on an SCK edge while idle
// -----------------------------------------------------------------------------
module dmg_link_responder #(
    parameter int SYNC_STAGES    = 2,
    parameter int TIMEOUT_CYCLES = 4096
) (
    input  logic       clk,
    input  logic       res,
    input  logic       sck,
    input  logic       sin,
    output logic       sout,
    input  logic [7:0] tx_data,
    input  logic       tx_load,
    output logic       busy,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    output logic       err
);

    // The timeout counter only has to reach TIMEOUT_CYCLES-1.
    localparam int TW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [TW-1:0] TMO_LAST = TW'((TIMEOUT_CYCLES > 0) ? (TIMEOUT_CYCLES - 1) : 0);

    typedef enum logic {
        IDLE  = 1'b0,
        ARMED = 1'b1
    } state_t;

    // ---------------------------------------------------------------- sync
    logic [SYNC_STAGES-1:0] sck_sync_reg;
    logic [SYNC_STAGES-1:0] sin_sync_reg;
    logic                   sck_prev_reg;

    // The SCK stages are preset to the idle level so that reset cannot create
    // a false falling edge.
    always_ff @(posedge clk) begin
        if (res) begin
            sck_sync_reg <= '1;
            sin_sync_reg <= '0;
            sck_prev_reg <= 1'b1;
        end else begin
            sck_sync_reg <= {sck_sync_reg[SYNC_STAGES-2:0], sck};
            sin_sync_reg <= {sin_sync_reg[SYNC_STAGES-2:0], sin};
            sck_prev_reg <= sck_sync_reg[SYNC_STAGES-1];
        end
    end

    logic sck_s;
    logic sin_s;
    logic rise;
    logic fall;

    assign sck_s = sck_sync_reg[SYNC_STAGES-1];
    assign sin_s = sin_sync_reg[SYNC_STAGES-1];
    assign rise  = sck_s & ~sck_prev_reg;
    assign fall  = ~sck_s & sck_prev_reg;

    // ---------------------------------------------------------------- state
    state_t        state_reg,    state_next;
    logic [7:0]    sr_reg,       sr_next;
    logic [3:0]    cnt_reg,      cnt_next;
    logic [TW-1:0] tmo_reg,      tmo_next;
    logic          sout_reg,     sout_next;
    logic [7:0]    rx_data_reg,  rx_data_next;
    logic          rx_valid_reg, rx_valid_next;
    logic          err_reg,      err_next;

    always_ff @(posedge clk) begin
        if (res) begin
            state_reg    <= IDLE;
            sr_reg       <= '0;
            cnt_reg      <= '0;
            tmo_reg      <= '0;
            sout_reg     <= 1'b1;
            rx_data_reg  <= '0;
            rx_valid_reg <= 1'b0;
            err_reg      <= 1'b0;
        end else begin
            state_reg    <= state_next;
            sr_reg       <= sr_next;
            cnt_reg      <= cnt_next;
            tmo_reg      <= tmo_next;
            sout_reg     <= sout_next;
            rx_data_reg  <= rx_data_next;
            rx_valid_reg <= rx_valid_next;
            err_reg      <= err_next;
        end
    end

    always_comb begin
        state_next    = state_reg;
        sr_next       = sr_reg;
        cnt_next      = cnt_reg;
        tmo_next      = tmo_reg;
        sout_next     = sout_reg;
        rx_data_next  = rx_data_reg;
        rx_valid_next = 1'b0;
        err_next      = 1'b0;

        case (state_reg)
            IDLE: begin
                // The partner should not clock an unarmed responder.
                if (rise || fall) begin
                    err_next = 1'b1;
                end
                if (tx_load) begin
                    sr_next    = tx_data;
                    sout_next  = tx_data[7];
                    cnt_next   = '0;
                    tmo_next   = '0;
                    state_next = ARMED;
                end
            end

            ARMED: begin
                if (rise) begin
                    sr_next  = {sr_reg[6:0], sin_s};
                    cnt_next = cnt_reg + 4'd1;
                    tmo_next = '0;
                    if (cnt_reg == 4'd7) begin
                        rx_data_next  = {sr_reg[6:0], sin_s};
                        rx_valid_next = 1'b1;
                        state_next    = IDLE;
                    end
                end else if (fall) begin
                    // The rising edge has not yet shifted, so the first fall
                    // re-presents bit 7, which was already driven at load.
                    sout_next = sr_reg[7];
                    tmo_next  = '0;
                end else if (TIMEOUT_CYCLES != 0) begin
                    if (tmo_reg == TMO_LAST) begin
                        state_next = IDLE;
                        err_next   = 1'b1;
                        sout_next  = 1'b1;
                        tmo_next   = '0;
                    end else begin
                        tmo_next = tmo_reg + 1'b1;
                    end
                end
            end

            default: begin
                state_next = IDLE;
            end
        endcase
    end

    assign busy     = (state_reg == ARMED);
    assign sout     = sout_reg;
    assign rx_data  = rx_data_reg;
    assign rx_valid = rx_valid_reg;
    assign err      = err_reg;

endmodule

// File: tb/tb_dmg_link_responder.sv
// -----------------------------------------------------------------------------
// Testbench for dmg_link_responder. The design is built with SYNC_STAGES=3 and
// TIMEOUT_CYCLES=64.
//
// The bench drives inputs and samples outputs on the falling edge of clk. It
// counts rx_valid and err pulses by sampling on the rising edge.
//
// With three synchroniser stages, a pin change made at a falling edge takes
// effect at the fourth rising edge after it. The result is therefore visible
// at the fourth falling-edge sample.
// -----------------------------------------------------------------------------
module tb_dmg_link_responder;

    logic       clk;
    logic       res;
    logic       sck;
    logic       sin;
    logic       sout;
    logic [7:0] tx_data;
    logic       tx_load;
    logic       busy;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       err;

    int checks = 0;
    int errors = 0;
    int rx_pulses = 0;
    int err_pulses = 0;

    dmg_link_responder #(
        .SYNC_STAGES   (3),
        .TIMEOUT_CYCLES(64)
    ) dut (
        .clk     (clk),
        .res     (res),
        .sck     (sck),
        .sin     (sin),
        .sout    (sout),
        .tx_data (tx_data),
        .tx_load (tx_load),
        .busy    (busy),
        .rx_data (rx_data),
        .rx_valid(rx_valid),
        .err     (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Count the cycles in which each strobe is high, so that a pulse wider
    // than one cycle is also detected.
    always @(posedge clk) begin
        if (rx_valid === 1'b1) rx_pulses++;
        if (err === 1'b1) err_pulses++;
    end

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic load(input logic [7:0] d);
        tx_data = d;
        tx_load = 1'b1;
        tick(1);
        tx_load = 1'b0;
    endtask

    // One full SCK period with a half-period of 8 clk. The sout sample is
    // taken just before the rising edge.
    task automatic pulse(input logic sin_bit, output logic sout_seen);
        sck = 1'b0;
        sin = sin_bit;
        tick(8);
        sout_seen = sout;
        sck = 1'b1;
        tick(8);
    endtask

    task automatic test_reset;
        res = 1'b1;
        tick(3);
        res = 1'b0;
        tick(1);
        checks++; if (sout !== 1'b1) begin errors++; $display("FAIL reset_sout: got %b expected 1", sout); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", busy); end
        checks++; if (rx_data !== 8'h00) begin errors++; $display("FAIL reset_rx_data: got %h expected 00", rx_data); end
        checks++; if (rx_valid !== 1'b0) begin errors++; $display("FAIL reset_rx_valid: got %b expected 0", rx_valid); end
        checks++; if (err !== 1'b0) begin errors++; $display("FAIL reset_err: got %b expected 0", err); end
    endtask

    task automatic test_basic;
        logic [7:0] seen;
        logic [7:0] rxb;
        int r0;
        int e0;
        rxb = 8'h3C;
        r0 = rx_pulses;
        e0 = err_pulses;
        load(8'hA5);
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL basic_busy_armed: got %b expected 1", busy); end
        checks++; if (sout !== 1'b1) begin errors++; $display("FAIL basic_sout_load: got %b expected 1", sout); end
        for (int i = 0; i < 8; i++) begin
            sck = 1'b0;
            sin = rxb[7-i];
            tick(8);
            seen[7-i] = sout;
            sck = 1'b1;
            if (i < 7) tick(8);
        end
        tick(3);
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL basic_busy_before: got %b expected 1", busy); end
        tick(1);
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL basic_busy_after: got %b expected 0", busy); end
        checks++; if (rx_valid !== 1'b1) begin errors++; $display("FAIL basic_rx_valid: got %b expected 1", rx_valid); end
        checks++; if (rx_data !== 8'h3C) begin errors++; $display("FAIL basic_rx_data: got %h expected 3c", rx_data); end
        tick(1);
        checks++; if (rx_valid !== 1'b0) begin errors++; $display("FAIL basic_rx_valid_width: got %b expected 0", rx_valid); end
        checks++; if (seen !== 8'hA5) begin errors++; $display("FAIL basic_sout_seq: got %h expected a5", seen); end
        checks++; if (sout !== 1'b1) begin errors++; $display("FAIL basic_sout_hold: got %b expected 1", sout); end
        checks++; if (rx_pulses - r0 !== 1) begin errors++; $display("FAIL basic_rx_pulses: got %0d expected 1", rx_pulses - r0); end
        checks++; if (err_pulses - e0 !== 0) begin errors++; $display("FAIL basic_err_pulses: got %0d expected 0", err_pulses - e0); end
        $display("basic xfer: sent %h received %h", seen, rx_data);
        tick(3);
    endtask

    task automatic test_back_to_back;
        logic [7:0] seen;
        logic b;
        int r0;
        r0 = rx_pulses;
        load(8'hFF);
        for (int i = 0; i < 8; i++) begin
            sck = 1'b0;
            sin = 1'b1;
            tick(8);
            seen[7-i] = sout;
            sck = 1'b1;
            if (i < 7) tick(8);
        end
        tick(3);
        // This strobe is sampled in the completion cycle and must be ignored.
        tx_data = 8'h55;
        tx_load = 1'b1;
        tick(1);
        tx_load = 1'b0;
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL b2b_load_ignored: got busy %b expected 0", busy); end
        checks++; if (rx_data !== 8'hFF) begin errors++; $display("FAIL b2b_rx_first: got %h expected ff", rx_data); end
        checks++; if (seen !== 8'hFF) begin errors++; $display("FAIL b2b_sout_first: got %h expected ff", seen); end
        $display("b2b xfer 1: sent %h received %h", seen, rx_data);
        load(8'h00);
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL b2b_second_armed: got %b expected 1", busy); end
        checks++; if (sout !== 1'b0) begin errors++; $display("FAIL b2b_sout_load: got %b expected 0", sout); end
        for (int i = 0; i < 8; i++) begin
            pulse(1'b1, b);
            seen[7-i] = b;
        end
        checks++; if (seen !== 8'h00) begin errors++; $display("FAIL b2b_sout_second: got %h expected 00", seen); end
        checks++; if (rx_data !== 8'hFF) begin errors++; $display("FAIL b2b_rx_second: got %h expected ff", rx_data); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL b2b_busy_end: got %b expected 0", busy); end
        checks++; if (rx_pulses - r0 !== 2) begin errors++; $display("FAIL b2b_rx_pulses: got %0d expected 2", rx_pulses - r0); end
        $display("b2b xfer 2: sent %h received %h", seen, rx_data);
    endtask

    task automatic test_idle_edge;
        int e0;
        e0 = err_pulses;
        sck = 1'b0;
        tick(8);
        checks++; if (err_pulses - e0 !== 1) begin errors++; $display("FAIL idle_err_fall: got %0d pulses expected 1", err_pulses - e0); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL idle_busy: got %b expected 0", busy); end
        checks++; if (rx_data !== 8'hFF) begin errors++; $display("FAIL idle_rx_data: got %h expected ff", rx_data); end
        checks++; if (sout !== 1'b0) begin errors++; $display("FAIL idle_sout: got %b expected 0", sout); end
        sck = 1'b1;
        tick(8);
        checks++; if (err_pulses - e0 !== 2) begin errors++; $display("FAIL idle_err_rise: got %0d pulses expected 2", err_pulses - e0); end
        $display("idle edge: err pulses %0d", err_pulses - e0);
    endtask

    task automatic test_timeout;
        logic b;
        int r0;
        int e0;
        r0 = rx_pulses;
        e0 = err_pulses;
        load(8'h81);
        pulse(1'b1, b);
        pulse(1'b0, b);
        sck = 1'b0;
        sin = 1'b1;
        tick(8);
        sck = 1'b1;
        // The rise acts 4 cycles after the pin change. The abort comes 64
        // cycles after that.
        tick(67);
        checks++; if (err !== 1'b0) begin errors++; $display("FAIL tmo_err_early: got %b expected 0", err); end
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL tmo_busy_early: got %b expected 1", busy); end
        checks++; if (sout !== 1'b0) begin errors++; $display("FAIL tmo_sout_early: got %b expected 0", sout); end
        tick(1);
        checks++; if (err !== 1'b1) begin errors++; $display("FAIL tmo_err: got %b expected 1", err); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL tmo_busy: got %b expected 0", busy); end
        checks++; if (sout !== 1'b1) begin errors++; $display("FAIL tmo_sout: got %b expected 1", sout); end
        checks++; if (rx_data !== 8'hFF) begin errors++; $display("FAIL tmo_rx_data: got %h expected ff", rx_data); end
        tick(2);
        checks++; if (err_pulses - e0 !== 1) begin errors++; $display("FAIL tmo_err_pulses: got %0d expected 1", err_pulses - e0); end
        checks++; if (rx_pulses - r0 !== 0) begin errors++; $display("FAIL tmo_rx_pulses: got %0d expected 0", rx_pulses - r0); end
        $display("timeout xfer: aborted, rx_data %h", rx_data);
    endtask

    task automatic test_reset_mid;
        logic [7:0] seen;
        logic [7:0] rxb;
        logic b;
        int r0;
        int e0;
        load(8'h3C);
        for (int i = 0; i < 4; i++) pulse(1'b1, b);
        r0 = rx_pulses;
        e0 = err_pulses;
        res = 1'b1;
        tick(1);
        res = 1'b0;
        checks++; if (sout !== 1'b1) begin errors++; $display("FAIL rstmid_sout: got %b expected 1", sout); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rstmid_busy: got %b expected 0", busy); end
        checks++; if (rx_data !== 8'h00) begin errors++; $display("FAIL rstmid_rx_data: got %h expected 00", rx_data); end
        checks++; if (rx_valid !== 1'b0) begin errors++; $display("FAIL rstmid_rx_valid: got %b expected 0", rx_valid); end
        checks++; if (err !== 1'b0) begin errors++; $display("FAIL rstmid_err: got %b expected 0", err); end
        tick(8);
        checks++; if (rx_pulses - r0 !== 0) begin errors++; $display("FAIL rstmid_rx_pulses: got %0d expected 0", rx_pulses - r0); end
        checks++; if (err_pulses - e0 !== 0) begin errors++; $display("FAIL rstmid_err_pulses: got %0d expected 0", err_pulses - e0); end
        rxb = 8'hC3;
        load(8'h5A);
        for (int i = 0; i < 8; i++) begin
            pulse(rxb[7-i], b);
            seen[7-i] = b;
        end
        checks++; if (seen !== 8'h5A) begin errors++; $display("FAIL rstmid_sout_seq: got %h expected 5a", seen); end
        checks++; if (rx_data !== 8'hC3) begin errors++; $display("FAIL rstmid_rx_data_new: got %h expected c3", rx_data); end
        checks++; if (rx_pulses - r0 !== 1) begin errors++; $display("FAIL rstmid_rx_new_pulses: got %0d expected 1", rx_pulses - r0); end
        $display("post-reset xfer: sent %h received %h", seen, rx_data);
    endtask

    task automatic test_latency;
        logic b;
        load(8'h40);
        checks++; if (sout !== 1'b0) begin errors++; $display("FAIL lat_sout_load: got %b expected 0", sout); end
        pulse(1'b0, b);
        // The second fall drives bit 6, which is 1.
        sck = 1'b0;
        sin = 1'b0;
        tick(3);
        checks++; if (sout !== 1'b0) begin errors++; $display("FAIL lat_sout_3: got %b expected 0", sout); end
        tick(1);
        checks++; if (sout !== 1'b1) begin errors++; $display("FAIL lat_sout_4: got %b expected 1", sout); end
        tick(4);
        sck = 1'b1;
        tick(8);
        for (int i = 0; i < 6; i++) pulse(1'b1, b);
        checks++; if (rx_data !== 8'h3F) begin errors++; $display("FAIL lat_rx_data: got %h expected 3f", rx_data); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL lat_busy_end: got %b expected 0", busy); end
        $display("latency xfer: sent 40 received %h", rx_data);
    endtask

    initial begin
        res = 1'b1;
        sck = 1'b1;
        sin = 1'b0;
        tx_data = 8'h00;
        tx_load = 1'b0;
        tick(1);
        test_reset;
        test_basic;
        test_back_to_back;
        test_idle_edge;
        test_timeout;
        test_reset_mid;
        test_latency;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
